fdiv_issue_sched: RTL and testbench
===================================

// Module: fdiv_issue_sched
// PURPOSE
//  Age-ordered issue buffer and scheduler in front of the single iterative FP divide/sqrt unit.
//  Accepts div/sqrt uops from NUM_PORTS FP issue ports and holds them in a DEPTH-entry buffer.
//  Issues the oldest entry (by sqN) to the divider whenever the divider is idle.
//  Squashes buffered and in-flight uops on branch mispredict.
// PARAMETERS
//  NUM_PORTS  2  FP issue ports feeding the divider
//  DEPTH      4  buffer entries; must be >= NUM_PORTS
// PORTS
//  clk         in   1                      clock
//  rst         in   1                      reset
//  IN_uop      in   EX_UOp[NUM_PORTS]      div/sqrt uops from issue ports
//  OUT_stall   out  NUM_PORTS              per-port backpressure, registered
//  IN_branch   in   BranchProv             mispredict/flush info
//  OUT_divUop  out  EX_UOp                 uop to divider, registered, 1-cycle valid pulse
//  IN_divBusy  in   1                      divider busy, including pending result
//  IN_divDone  in   1                      divider result written back this cycle
//  OUT_inFlight out 1                      a uop is in the divider
// BEHAVIOUR
//  - Reset: rst is synchronous, active-high; clk is the clock.
//    At reset: all entries invalid; OUT_stall=0; OUT_divUop.valid=0; OUT_inFlight=0.
//    A reset mid-operation drops all entries and the in-flight record.
//  - Young test: a uop is young when $signed(sqN - IN_branch.sqN) > 0 and IN_branch.taken=1.
//  - Enqueue: each IN_uop[i] with valid=1 and OUT_stall[i]=0 is written at the clock edge.
//    Young incoming uops are dropped.
//    Writes go to free slots; port 0 takes the lowest free index.
//    Up to NUM_PORTS writes per cycle.
//  - Stall: OUT_stall[all] <= (count_next > DEPTH-NUM_PORTS).
//    This is registered and conservative, so it never overflows.
//    IN_uop.valid while stalled is a protocol error; the block ignores it.
//  - Issue condition: buffer non-empty, IN_divBusy=0, OUT_divUop.valid=0, OUT_inFlight=0.
//    When true, select the oldest valid entry: the minimum by signed sqN difference.
//    Ties cannot occur (sqN is unique).
//    Register the selected entry into OUT_divUop with valid=1 and free its slot.
//    OUT_divUop.valid is a one-cycle pulse.
//  - Flush and issue: a young selected entry is flushed, not issued.
//    Arbitration that cycle skips young entries.
//  - Flush: on IN_branch.taken, invalidate every young entry in the same edge.
//    Clear OUT_inFlight if the in-flight sqN is young; the divider squashes its own result.
//  - In-flight: set when OUT_divUop issues.
//    Cleared on IN_divDone or flush.
//    IN_divDone and a new issue in the same cycle is legal; set wins.
//  - Latency (no bypass): uop valid in cycle N, written at edge N.
//    Selected in N+1, OUT_divUop.valid in N+2 when the divider is idle.
//  - Simultaneous enqueue + issue + flush: all apply at the same edge.
//    count_next = count + writes - issue - flushed.
//  - Full buffer: stall stays asserted and issue continues.
//    Empty buffer: no issue and OUT_divUop.valid=0.
// CONFIGURATION
//  FDIV_SCHED_BYPASS_EN defined:
//    If the buffer is empty and the issue condition on divider state holds, the oldest
//    non-young incoming uop is registered directly into OUT_divUop in cycle N+1.
//    Other incoming uops enqueue normally.
//  FDIV_SCHED_BYPASS_EN undefined:
//    All uops pass through the buffer; minimum latency is 2.
// STRUCTURE
//  - Shared package: FDIV_SCHED_DEPTH_DEFAULT, and the typedef FDivSlot.
//    FDivSlot = {valid, EX_UOp uop}.
//    Also an age-compare function: is_older(a, b) via signed sqN difference.
//    EX_UOp and BranchProv come from the existing package.
//  - Sub-module fdiv_age_select: combinational oldest-valid-entry picker.
//    Inputs: DEPTH slots + branch.
//    Outputs: one-hot select + found.
//    Implemented as a reduction tree.
// TESTING
//  1 Single uop sqN=5 on port 0, divider idle.
//    -> OUT_divUop.valid in cycle N+2 (N+1 with bypass) with sqN=5, then OUT_inFlight=1.
//  2 Ports 0/1 send sqN=9/7 together, IN_divBusy=1 for 10 cycles.
//    -> after busy drops, sqN=7 issues first, then sqN=9 once IN_divDone.
//  3 Fill 4 entries with divider busy.
//    -> OUT_stall=1 once count>2; no entry lost; count never exceeds 4.
//  4 Buffer holds sqN 3,6,8; branch taken sqN=5.
//    -> 6 and 8 removed at that edge; only 3 issues.
//    In-flight sqN=7 at the same time -> OUT_inFlight clears.
//  5 Branch sqN=4 in the same cycle as incoming sqN=6 and the selected entry sqN=5.
//    -> neither enqueued nor issued; OUT_divUop.valid stays 0.
//  6 rst asserted with 3 entries and one in flight.
//    -> next cycle: empty, OUT_stall=0, OUT_inFlight=0, no issue.

Source files
------------

// File: rtl/fdiv_issue_sched_pkg.sv
// Shared types for the FP divide/sqrt issue scheduler.
// EX_UOp / BranchProv mirror the core-wide definitions.
package fdiv_issue_sched_pkg;

  localparam int FDIV_SCHED_DEPTH_DEFAULT = 4;
  localparam int SQN_W = 7;

  typedef logic [SQN_W-1:0] SqN;

  typedef struct packed {
    logic        valid;
    SqN          sqN;
    logic [6:0]  tagDst;
    logic [3:0]  opcode;
    logic [31:0] srcA;
    logic [31:0] srcB;
  } EX_UOp;

  typedef struct packed {
    logic taken;
    SqN   sqN;
  } BranchProv;

  typedef struct packed {
    logic  valid;
    EX_UOp uop;
  } FDivSlot;

  function automatic logic is_older(SqN a, SqN b);
    SqN d;
    d = a - b;
    return d[SQN_W-1];
  endfunction

  function automatic logic is_young(SqN s, BranchProv br);
    SqN d;
    d = s - br.sqN;
    return br.taken && (d != '0) && !d[SQN_W-1];
  endfunction

endpackage

// File: rtl/fdiv_issue_sched_if.sv
// Handshake bundle between FP issue ports, branch unit and divider.
// master drives uops/branch/divider state; slave is the scheduler.
interface fdiv_issue_sched_if #(
  parameter int NUM_PORTS = 2
);
  import fdiv_issue_sched_pkg::*;

  EX_UOp                IN_uop [NUM_PORTS];
  logic [NUM_PORTS-1:0] OUT_stall;
  BranchProv            IN_branch;
  EX_UOp                OUT_divUop;
  logic                 IN_divBusy;
  logic                 IN_divDone;
  logic                 OUT_inFlight;

  modport master (
    output IN_uop, IN_branch, IN_divBusy, IN_divDone,
    input  OUT_stall, OUT_divUop, OUT_inFlight
  );

  modport slave (
    input  IN_uop, IN_branch, IN_divBusy, IN_divDone,
    output OUT_stall, OUT_divUop, OUT_inFlight
  );

endinterface

// File: rtl/fdiv_issue_sched_age_select.sv
// Oldest non-squashed valid slot picker, built as a pairwise
// reduction tree over sqN age.
module fdiv_age_select
  import fdiv_issue_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  FDivSlot          slots_i [DEPTH],
  input  BranchProv        branch_i,
  output logic [DEPTH-1:0] sel_o,
  output logic             found_o
);

  localparam int LVL = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int P   = 1 << LVL;

  logic           cv [LVL+1][P];
  logic [LVL-1:0] ci [LVL+1][P];
  SqN             cs [LVL+1][P];
  logic           unused_bits;

  always_comb begin
    unused_bits = 1'b0;
    for (int l = 0; l <= LVL; l++) begin
      for (int i = 0; i < P; i++) begin
        cv[l][i] = 1'b0;
        ci[l][i] = LVL'(i);
        cs[l][i] = '0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      cv[0][i] = slots_i[i].valid &&
                 !is_young(slots_i[i].uop.sqN, branch_i);
      cs[0][i] = slots_i[i].uop.sqN;
      unused_bits = unused_bits ^ (^slots_i[i].uop);
    end
    // b wins only if valid and strictly older than a
    for (int l = 0; l < LVL; l++) begin
      for (int i = 0; i < (P >> (l + 1)); i++) begin
        if (cv[l][2*i+1] &&
            (!cv[l][2*i] || is_older(cs[l][2*i+1], cs[l][2*i]))) begin
          cv[l+1][i] = 1'b1;
          ci[l+1][i] = ci[l][2*i+1];
          cs[l+1][i] = cs[l][2*i+1];
        end else begin
          cv[l+1][i] = cv[l][2*i];
          ci[l+1][i] = ci[l][2*i];
          cs[l+1][i] = cs[l][2*i];
        end
      end
    end
    found_o = cv[LVL][0];
    for (int s = 0; s < DEPTH; s++) begin
      sel_o[s] = cv[LVL][0] && (ci[LVL][0] == LVL'(s));
    end
  end

endmodule

// File: rtl/fdiv_issue_sched.sv
// Age-ordered issue buffer in front of the iterative FP div/sqrt unit.
// Define FDIV_SCHED_BYPASS_EN to let an incoming uop skip an empty buffer.
module fdiv_issue_sched
  import fdiv_issue_sched_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int DEPTH     = FDIV_SCHED_DEPTH_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  fdiv_issue_sched_if.slave  bus
);

  FDivSlot              slots_q [DEPTH];
  FDivSlot              slots_d [DEPTH];
  logic                 stall_q, stall_d;
  EX_UOp                div_uop_q, div_uop_d;
  logic                 in_flight_q, in_flight_d;
  SqN                   in_flight_sqn_q, in_flight_sqn_d;

  logic [DEPTH-1:0]     sel;
  logic                 found;
  logic                 issue_ok;
  logic                 empty_q;
  logic                 issue;
  logic [NUM_PORTS-1:0] take;
  logic [DEPTH-1:0]     free;
  logic                 placed;
  int                   cnt;
`ifdef FDIV_SCHED_BYPASS_EN
  logic                 bp_found;
  int                   bp_idx;
`endif

  fdiv_age_select #(.DEPTH(DEPTH)) u_sel (
    .slots_i  (slots_q),
    .branch_i (bus.IN_branch),
    .sel_o    (sel),
    .found_o  (found)
  );

  always_comb begin
    empty_q = 1'b1;
    for (int s = 0; s < DEPTH; s++) begin
      if (slots_q[s].valid) empty_q = 1'b0;
    end
    issue_ok = !bus.IN_divBusy && !div_uop_q.valid && !in_flight_q;
  end

  always_comb begin
    slots_d   = slots_q;
    div_uop_d = '0;
    issue     = 1'b0;
    free      = '0;
    placed    = 1'b0;
    cnt       = 0;
    for (int s = 0; s < DEPTH; s++) begin
      free[s] = !slots_q[s].valid;
      if (slots_q[s].valid &&
          is_young(slots_q[s].uop.sqN, bus.IN_branch)) begin
        slots_d[s].valid = 1'b0;
      end
    end
    if (issue_ok && found) begin
      for (int s = 0; s < DEPTH; s++) begin
        if (sel[s]) begin
          div_uop_d        = slots_q[s].uop;
          div_uop_d.valid  = 1'b1;
          slots_d[s].valid = 1'b0;
        end
      end
      issue = 1'b1;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      take[p] = bus.IN_uop[p].valid && !stall_q &&
                !is_young(bus.IN_uop[p].sqN, bus.IN_branch);
    end
`ifdef FDIV_SCHED_BYPASS_EN
    bp_found = 1'b0;
    bp_idx   = 0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (take[p] && (!bp_found ||
          is_older(bus.IN_uop[p].sqN, bus.IN_uop[bp_idx].sqN))) begin
        bp_found = 1'b1;
        bp_idx   = p;
      end
    end
    if (issue_ok && empty_q && bp_found) begin
      div_uop_d       = bus.IN_uop[bp_idx];
      div_uop_d.valid = 1'b1;
      take[bp_idx]    = 1'b0;
      issue           = 1'b1;
    end
`endif
    // stall guarantees NUM_PORTS free slots before this edge
    for (int p = 0; p < NUM_PORTS; p++) begin
      placed = 1'b0;
      for (int s = 0; s < DEPTH; s++) begin
        if (take[p] && !placed && free[s]) begin
          slots_d[s].valid = 1'b1;
          slots_d[s].uop   = bus.IN_uop[p];
          free[s]          = 1'b0;
          placed           = 1'b1;
        end
      end
    end
    for (int s = 0; s < DEPTH; s++) begin
      cnt = cnt + int'(slots_d[s].valid);
    end
    stall_d = cnt > (DEPTH - NUM_PORTS);
  end

  always_comb begin
    in_flight_d     = in_flight_q;
    in_flight_sqn_d = in_flight_sqn_q;
    if (bus.IN_divDone) in_flight_d = 1'b0;
    if (in_flight_q && is_young(in_flight_sqn_q, bus.IN_branch)) begin
      in_flight_d = 1'b0;
    end
    if (issue) begin
      in_flight_d     = 1'b1;
      in_flight_sqn_d = div_uop_d.sqN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) slots_q[s] <= '0;
      stall_q         <= 1'b0;
      div_uop_q       <= '0;
      in_flight_q     <= 1'b0;
      in_flight_sqn_q <= '0;
    end else begin
      slots_q         <= slots_d;
      stall_q         <= stall_d;
      div_uop_q       <= div_uop_d;
      in_flight_q     <= in_flight_d;
      in_flight_sqn_q <= in_flight_sqn_d;
    end
  end

  assign bus.OUT_stall    = {NUM_PORTS{stall_q}};
  assign bus.OUT_divUop   = div_uop_q;
  assign bus.OUT_inFlight = in_flight_q;

endmodule

// File: tb/tb_fdiv_issue_sched.sv
// Random stimulus against a queue-based model of the div/sqrt scheduler.
// Build with +define+FDIV_SCHED_BYPASS_EN to cover the bypass variant.
module tb_fdiv_issue_sched;
  import fdiv_issue_sched_pkg::*;

  localparam int NP = 2;
  localparam int D  = 4;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fdiv_issue_sched_if #(.NUM_PORTS(NP)) bus ();

  fdiv_issue_sched #(.NUM_PORTS(NP), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, int obs, int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // model state
  int m_buf[$];
  bit m_stall, m_ov, m_inf;
  int m_osqn, m_inf_sqn;
  int div_left, div_sqn;
  int next_sqn;

  function automatic int sdiff(int a, int b);
    int d;
    d = (a - b) & 127;
    if (d >= 64) d -= 128;
    return d;
  endfunction

  function automatic bit young(int s, bit tk, int bs);
    return tk && (sdiff(s, bs) > 0);
  endfunction

  function automatic int tag_of(int s);
    return (s ^ 'h55) & 127;
  endfunction

  task automatic model_reset();
    m_buf.delete();
    m_stall = 0; m_ov = 0; m_inf = 0;
    m_osqn = 0; m_inf_sqn = 0;
    div_left = 0; div_sqn = 0;
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < NP; p++) bus.IN_uop[p] = '0;
    bus.IN_branch  = '0;
    bus.IN_divBusy = 1'b0;
    bus.IN_divDone = 1'b0;
  endtask

  initial begin
    bit busy, done, tk, empty0, ok, iss;
    int bs, k, o;
    int nb[$];
    int takers[$];
    int sq [NP];
    bit vld [NP];

    rst = 1'b1;
    idle_inputs();
    model_reset();
    next_sqn = 5;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      check("stall", int'(bus.OUT_stall), m_stall ? (1 << NP) - 1 : 0);
      check("div_valid", int'(bus.OUT_divUop.valid), int'(m_ov));
      if (m_ov) begin
        check("div_sqn", int'(bus.OUT_divUop.sqN), m_osqn);
        check("div_tag", int'(bus.OUT_divUop.tagDst), tag_of(m_osqn));
      end
      check("in_flight", int'(bus.OUT_inFlight), int'(m_inf));

      rst = 1'b0;
      if (cyc == NCYC / 2) begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        continue;
      end

      busy = div_left > 0;
      done = div_left == 1;
      tk = ($urandom_range(0, 9) == 0);
      bs = (next_sqn - int'($urandom_range(1, 5))) & 127;

      for (int p = 0; p < NP; p++) begin
        vld[p] = ($urandom_range(0, 1) == 1);
        sq[p]  = 0;
      end
      for (int p = 0; p < NP; p++) begin
        if (vld[p]) begin
          sq[p] = next_sqn;
          next_sqn = (next_sqn + 1) & 127;
        end
      end
      if (vld[0] && vld[1] && $urandom_range(0, 1) == 1) begin
        k = sq[0]; sq[0] = sq[1]; sq[1] = k;
      end

      for (int p = 0; p < NP; p++) begin
        bus.IN_uop[p]        = '0;
        bus.IN_uop[p].valid  = vld[p];
        bus.IN_uop[p].sqN    = SqN'(sq[p]);
        bus.IN_uop[p].tagDst = 7'(tag_of(sq[p]));
        bus.IN_uop[p].srcA   = $urandom;
      end
      bus.IN_branch.taken = tk;
      bus.IN_branch.sqN   = SqN'(bs);
      bus.IN_divBusy      = busy;
      bus.IN_divDone      = done;

      // reference step for the coming edge
      empty0 = (m_buf.size() == 0);
      ok = !busy && !m_ov && !m_inf;
      nb.delete();
      foreach (m_buf[i]) if (!young(m_buf[i], tk, bs)) nb.push_back(m_buf[i]);
      iss = 0;
      o = 0;
      if (ok && nb.size() > 0) begin
        k = 0;
        foreach (nb[i]) if (sdiff(nb[i], nb[k]) < 0) k = i;
        o = nb[k];
        nb.delete(k);
        iss = 1;
      end
      takers.delete();
      for (int p = 0; p < NP; p++) begin
        if (vld[p] && !m_stall && !young(sq[p], tk, bs)) takers.push_back(sq[p]);
      end
`ifdef FDIV_SCHED_BYPASS_EN
      if (!iss && ok && empty0 && takers.size() > 0) begin
        k = 0;
        foreach (takers[i]) if (sdiff(takers[i], takers[k]) < 0) k = i;
        o = takers[k];
        takers.delete(k);
        iss = 1;
      end
`else
      if (empty0) k = 0;
`endif
      foreach (takers[i]) nb.push_back(takers[i]);

      if (div_left > 0) begin
        if (young(div_sqn, tk, bs)) div_left = 0;
        else div_left--;
      end
      if (m_ov && !young(m_osqn, tk, bs)) begin
        div_left = $urandom_range(1, 8);
        div_sqn  = m_osqn;
      end

      if (done) m_inf = 0;
      if (m_inf && young(m_inf_sqn, tk, bs)) m_inf = 0;
      if (iss) begin
        m_inf = 1;
        m_inf_sqn = o;
      end
      m_ov = iss;
      m_osqn = o;
      m_buf = nb;
      m_stall = m_buf.size() > (D - NP);
      if (tk) next_sqn = (bs + 1) & 127;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
